// File: rtl/inimigo_pkg.sv
// inimigo_pkg: shared types for the enemy fleet.
// Holds the fleet state encoding and the coordinate width.
package inimigo_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    MARCHA  = 2'd0,
    VITORIA = 2'd1,
    INVASAO = 2'd2
  } estado_t;

endpackage

// File: rtl/frota_extremos.sv
// frota_extremos: lowest/highest set index of the alive mask.
// Ports: vivos in; esq (lowest alive), dir (highest alive) out.
module frota_extremos #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vivos,
  output logic [$clog2(N)-1:0] esq,
  output logic [$clog2(N)-1:0] dir
);
  import inimigo_pkg::*;

  localparam int IW = $clog2(N);

  always_comb begin
    esq = '0;
    dir = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vivos[i]) esq = IW'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (vivos[i]) dir = IW'(i);
    end
  end

endmodule

// File: rtl/inimigo_frota.sv
// inimigo_frota: a row of enemies marching as one unit.
// In: CLOCK_50, reset(n), pausa, reiniciarJogo, acerto, acerto_idx.
// Out: x/y/largura/altura/vivos/direcao for the renderer;
//      passo pulse; onda_limpa and invasao levels for game control.
module inimigo_frota #(
  parameter int N_INIMIGOS = 8,
  parameter int LARGURA    = 11,
  parameter int ALTURA     = 8,
  parameter int ESPACO     = 16,
  parameter int X_INICIAL  = 300,
  parameter int Y_INICIAL  = 300,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 640,
  parameter int PASSO_X    = 2,
  parameter int PASSO_Y    = 8,
  parameter int Y_LIMITE   = 440,
  parameter int DIV_TICK   = 833333
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          pausa,
  input  logic                          reiniciarJogo,
  input  logic                          acerto,
  input  logic [$clog2(N_INIMIGOS)-1:0] acerto_idx,
  output logic [9:0]                    largura,
  output logic [9:0]                    altura,
  output logic [9:0]                    x,
  output logic [9:0]                    y,
  output logic [N_INIMIGOS-1:0]         vivos,
  output logic                          direcao,
  output logic                          passo,
  output logic                          onda_limpa,
  output logic                          invasao
);
  import inimigo_pkg::*;

  localparam int IW = $clog2(N_INIMIGOS);
  localparam int CW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int EW = COORD_W + 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_TICK - 1);
  localparam logic [COORD_W-1:0] X0 = COORD_W'(X_INICIAL);
  localparam logic [COORD_W-1:0] Y0 = COORD_W'(Y_INICIAL);
  localparam logic [COORD_W-1:0] DX = COORD_W'(PASSO_X);
  localparam logic [EW-1:0] LIM_ESQ = EW'(X_MIN + PASSO_X);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [COORD_W-1:0]    x_q, x_d;
  logic [COORD_W-1:0]    y_q, y_d;
  logic [N_INIMIGOS-1:0] vivos_q, vivos_d;
  logic                  dir_q, dir_d;
  logic                  passo_q, passo_d;
  estado_t               estado_q, estado_d;

  logic [IW-1:0] ext_esq;
  logic [IW-1:0] ext_dir;
  logic          tick;
  logic [EW-1:0] borda_dir;
  logic [EW-1:0] borda_esq;
  logic [EW-1:0] y_desc;
  logic          bate_dir;
  logic          bate_esq;
  logic          desce;
  logic          invade;
  logic          idx_ok;

  frota_extremos #(
    .N (N_INIMIGOS)
  ) u_extremos (
    .vivos (vivos_q),
    .esq   (ext_esq),
    .dir   (ext_dir)
  );

  assign tick = (cnt_q == CNT_MAX);

  // Edges are judged on the living extent only, in 11 bits.
  assign borda_dir = EW'(x_q)
                   + EW'(ext_dir) * EW'(ESPACO)
                   + EW'(LARGURA + PASSO_X);
  assign borda_esq = EW'(x_q)
                   + EW'(ext_esq) * EW'(ESPACO);
  assign bate_dir  = borda_dir > EW'(X_MAX);

  // The origin itself must also stay at or above X_MIN,
  // even when the leftmost columns are already dead.
  assign bate_esq  = (borda_esq < LIM_ESQ)
                   || (EW'(x_q) < LIM_ESQ);
  assign desce     = dir_q ? bate_dir : bate_esq;
  assign y_desc    = EW'(y_q) + EW'(PASSO_Y);
  assign invade    = (y_desc + EW'(ALTURA)) >= EW'(Y_LIMITE);
  assign idx_ok    = int'(acerto_idx) < N_INIMIGOS;

  always_comb begin
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    vivos_d  = vivos_q;
    dir_d    = dir_q;
    estado_d = estado_q;
    passo_d  = 1'b0;
    if (reiniciarJogo) begin
      cnt_d    = '0;
      x_d      = X0;
      y_d      = Y0;
      vivos_d  = '1;
      dir_d    = 1'b1;
      estado_d = MARCHA;
    end else if (!pausa) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      unique case (estado_q)
        MARCHA: begin
          if (vivos_q == '0) begin
            estado_d = VITORIA;
          end else if (tick) begin
            passo_d = 1'b1;
            if (desce) begin
              y_d   = y_desc[COORD_W-1:0];
              dir_d = ~dir_q;
              if (invade) estado_d = INVASAO;
            end else if (dir_q) begin
              x_d = x_q + DX;
            end else begin
              x_d = x_q - DX;
            end
          end
          // Move used the pre-kill mask; kill lands same edge.
          if (acerto && idx_ok) vivos_d[acerto_idx] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      x_q      <= X0;
      y_q      <= Y0;
      vivos_q  <= '1;
      dir_q    <= 1'b1;
      passo_q  <= 1'b0;
      estado_q <= MARCHA;
    end else begin
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vivos_q  <= vivos_d;
      dir_q    <= dir_d;
      passo_q  <= passo_d;
      estado_q <= estado_d;
    end
  end

  assign largura    = 10'(LARGURA);
  assign altura     = 10'(ALTURA);
  assign x          = x_q;
  assign y          = y_q;
  assign vivos      = vivos_q;
  assign direcao    = dir_q;
  assign passo      = passo_q;
  assign onda_limpa = (estado_q == VITORIA);
  assign invasao    = (estado_q == INVASAO);

endmodule

// File: tb/tb_inimigo_frota.sv
// tb_inimigo_frota: directed + random checks of inimigo_frota
// against an arithmetic fleet model; second DUT for invasion.
module tb_inimigo_frota;

  localparam int N    = 8;
  localparam int DIVT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, pausa, rein, acerto;
  logic [2:0] idx;
  logic [9:0] larg, alt, x, y;
  logic [7:0] vivos;
  logic       dir, passo, onda, inv;

  logic       rst_i;
  logic       zero = 1'b0;
  logic [2:0] zidx = 3'd0;
  logic [9:0] larg_i, alt_i, x_i, y_i;
  logic [7:0] vivos_i;
  logic       dir_i, passo_i, onda_i, inv_i;

  int n_cmp = 0;
  int n_err = 0;

  int m_x, m_y, m_dir, m_cnt, m_passo, m_mode;
  bit m_vivo [N];

  inimigo_frota #(
    .DIV_TICK (DIVT)
  ) u_dut (
    .CLOCK_50      (clk),
    .reset         (rst_n),
    .pausa         (pausa),
    .reiniciarJogo (rein),
    .acerto        (acerto),
    .acerto_idx    (idx),
    .largura       (larg),
    .altura        (alt),
    .x             (x),
    .y             (y),
    .vivos         (vivos),
    .direcao       (dir),
    .passo         (passo),
    .onda_limpa    (onda),
    .invasao       (inv)
  );

  inimigo_frota #(
    .DIV_TICK  (DIVT),
    .Y_INICIAL (420)
  ) u_inv (
    .CLOCK_50      (clk),
    .reset         (rst_i),
    .pausa         (zero),
    .reiniciarJogo (zero),
    .acerto        (zero),
    .acerto_idx    (zidx),
    .largura       (larg_i),
    .altura        (alt_i),
    .x             (x_i),
    .y             (y_i),
    .vivos         (vivos_i),
    .direcao       (dir_i),
    .passo         (passo_i),
    .onda_limpa    (onda_i),
    .invasao       (inv_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int vivos_mask();
    int m = 0;
    for (int i = 0; i < N; i++)
      if (m_vivo[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic m_reset();
    m_x = 300; m_y = 300; m_dir = 1;
    m_cnt = 0; m_passo = 0; m_mode = 0;
    for (int i = 0; i < N; i++) m_vivo[i] = 1'b1;
  endtask

  task automatic m_descend(input int nd);
    m_y += 8;
    m_dir = nd;
    if (m_y + 8 >= 440) m_mode = 2;
  endtask

  // One clock edge of fleet behaviour: mode 0 march,
  // 1 wave cleared, 2 invaded.
  task automatic m_step();
    bit t;
    int lo, hi;
    if (!rst_n || rein) begin
      m_reset();
      return;
    end
    m_passo = 0;
    if (pausa) return;
    t = (m_cnt == DIVT - 1);
    m_cnt = t ? 0 : m_cnt + 1;
    if (m_mode != 0) return;
    if (vivos_mask() == 0) begin
      m_mode = 1;
      return;
    end
    if (t) begin
      lo = -1; hi = -1;
      for (int i = 0; i < N; i++)
        if (m_vivo[i]) begin
          if (lo < 0) lo = i;
          hi = i;
        end
      m_passo = 1;
      if (m_dir == 1) begin
        if (m_x + hi * 16 + 11 + 2 > 640) m_descend(0);
        else m_x += 2;
      end else begin
        if (m_x + lo * 16 < 2 || m_x < 2) m_descend(1);
        else m_x -= 2;
      end
    end
    if (acerto && idx < N) m_vivo[idx] = 1'b0;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ":x"}, x, m_x);
    chk({tag, ":y"}, y, m_y);
    chk({tag, ":vivos"}, vivos, vivos_mask());
    chk({tag, ":dir"}, dir, m_dir);
    chk({tag, ":passo"}, passo, m_passo);
    chk({tag, ":onda"}, onda, (m_mode == 1));
    chk({tag, ":inv"}, inv, (m_mode == 2));
    chk({tag, ":larg"}, larg, 11);
    chk({tag, ":alt"}, alt, 8);
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
    cmp_all("step");
  endtask

  task automatic esperar_desc(input string tag);
    logic [9:0] y0;
    int k;
    y0 = y;
    k = 0;
    while (y == y0 && k < 3000) begin
      step();
      k++;
    end
    chk({tag, ":timeout"}, (k < 3000), 1);
  endtask

  initial begin
    int k;
    logic [9:0] xs, ys;
    rst_n = 0; rst_i = 0;
    pausa = 0; rein = 0; acerto = 0; idx = 0;
    m_reset();
    #23;
    cmp_all("reset");
    chk("reset_x", x, 300);
    chk("reset_vivos", vivos, 8'hFF);

    @(negedge clk);
    rst_n = 1;
    repeat (3) step();
    chk("t1_passo_pre", passo, 0);
    step();
    chk("t1_x", x, 302);
    chk("t1_passo", passo, 1);
    step();
    chk("t1_passo_low", passo, 0);

    esperar_desc("p2");
    chk("p2_x", x, 516);
    chk("p2_y", y, 308);
    chk("p2_dir", dir, 0);

    rein = 1; step(); rein = 0;
    for (int i = 4; i < 8; i++) begin
      acerto = 1; idx = 3'(i); step();
    end
    acerto = 0;
    esperar_desc("p3a");
    chk("p3a_x", x, 580);
    chk("p3a_y", y, 308);
    chk("p3a_dir", dir, 0);
    acerto = 1; idx = 0; step(); acerto = 0;
    esperar_desc("p3b");
    chk("p3b_x", x, 0);
    chk("p3b_y", y, 316);
    chk("p3b_dir", dir, 1);

    rein = 1; step(); rein = 0;
    step(); step();
    pausa = 1;
    for (int i = 0; i < 20 * DIVT; i++) begin
      acerto = (i % 5 == 0);
      idx = 3'(i % 8);
      step();
    end
    chk("p4_x", x, 300);
    chk("p4_y", y, 300);
    chk("p4_vivos", vivos, 8'hFF);
    pausa = 0;
    acerto = 1; idx = 3;
    step(); step();
    acerto = 0;
    chk("p4_kill3", vivos, 8'hF7);

    for (int i = 0; i < 8; i++) begin
      acerto = 1; idx = 3'(i); step();
    end
    acerto = 0;
    chk("p5_vivos0", vivos, 0);
    chk("p5_onda_pre", onda, 0);
    step();
    chk("p5_onda", onda, 1);
    xs = x; ys = y;
    repeat (10 * DIVT) step();
    chk("p5_xfrz", x, xs);
    chk("p5_yfrz", y, ys);
    rein = 1; step(); rein = 0;
    chk("p5_rx", x, 300);
    chk("p5_rvivos", vivos, 8'hFF);
    chk("p5_ronda", onda, 0);
    chk("p5_rdir", dir, 1);

    for (int i = 0; i < 1500; i++) begin
      pausa  = ($urandom_range(0, 9) == 0);
      acerto = ($urandom_range(0, 11) == 0);
      idx    = 3'($urandom_range(0, 7));
      rein   = ($urandom_range(0, 399) == 0);
      step();
    end
    pausa = 0; acerto = 0; rein = 0;

    @(negedge clk);
    rst_i = 1;
    k = 0;
    while (y_i == 420 && k < 3000) begin
      step(); k++;
    end
    chk("p6_t1", (k < 3000), 1);
    chk("p6_y1", y_i, 428);
    chk("p6_inv1", inv_i, 0);
    k = 0;
    while (y_i == 428 && k < 3000) begin
      step(); k++;
    end
    chk("p6_t2", (k < 3000), 1);
    chk("p6_y2", y_i, 436);
    chk("p6_x2", x_i, 0);
    chk("p6_inv2", inv_i, 1);
    repeat (10 * DIVT) step();
    chk("p6_yfrz", y_i, 436);
    chk("p6_xfrz", x_i, 0);
    chk("p6_invfrz", inv_i, 1);

    @(negedge clk);
    #1;
    rst_i = 0;
    rst_n = 0;
    #1;
    chk("p6_ax", x_i, 300);
    chk("p6_ay", y_i, 420);
    chk("p6_ainv", inv_i, 0);
    chk("p6_avivos", vivos_i, 8'hFF);
    chk("p6_adir", dir_i, 1);
    chk("p6_apasso", passo_i, 0);
    m_reset();
    cmp_all("async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
